// File: rtl/irq_priority_ctrl.sv
// ============================================================================
// irq_priority_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   This block sits downstream of the per-source IRQ input unit. It looks at
//   the enabled request vector and picks a single winner. The highest
//   programmed priority level wins, and on equal levels the lowest source
//   index wins. A source can only win if its level is above the CPU mask
//   level. Level 0 never wins.
//
//   The winner is locked for one cycle while its request is re-checked. Then
//   it is either
//     - presented to the CPU as a vectored interrupt (req/ack handshake), or
//     - handed to the DTC when its DTCER bit is set.
//   interrupt_exception_handling and DTC_activate go back to the input unit,
//   which clears the serviced source's pending flag.
//
// Configuration:
//   IRQ_ACK_TIMEOUT_EN  When defined, an un-acknowledged CPU request is
//                       abandoned after ACK_TIMEOUT cycles in CPU_REQ and the
//                       sticky ack_err flag is set. When undefined, CPU_REQ
//                       waits indefinitely and ack_err is tied to 0.
//
// Parameters:
//   NUM_IRQ      number of request sources
//   PRIO_W       width of each source priority level
//   VEC_BASE     vector number of source 0 (source n uses VEC_BASE+n)
//   ACK_TIMEOUT  cycles to wait for cpu_ack (timeout build only)
//
// Ports:
//   clk                           system clock
//   rst_n                         asynchronous active-low reset
//   IRQ_req       [NUM_IRQ]       pending-and-enabled requests, bit n = src n
//   IPR_dataout   [NUM_IRQ*PRIO_W] priority level per source
//   DTCER_dataout [NUM_IRQ]       1 = source serviced by the DTC
//   cpu_mask      [PRIO_W]        current CPU interrupt mask level
//   cpu_ack                       CPU accepts the presented vector
//   dtc_done                      DTC transfer finished
//   int_req                       interrupt request to the CPU
//   int_vector    [8]             vector of the locked winner
//   int_level     [PRIO_W]        priority level of the locked winner
//   interrupt_exception_handling  one-cycle pulse when the CPU accepts
//   DTC_activate                  DTC service active
//   Disel                         1 = current service is a DTC transfer
//   ack_err                       sticky ack-timeout flag
// ============================================================================
module irq_priority_ctrl #(
    parameter int         NUM_IRQ     = 16,
    parameter int         PRIO_W      = 3,
    parameter logic [7:0] VEC_BASE    = 8'd64,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IRQ-1:0]          IRQ_req,
    input  logic [NUM_IRQ*PRIO_W-1:0]   IPR_dataout,
    input  logic [NUM_IRQ-1:0]          DTCER_dataout,
    input  logic [PRIO_W-1:0]           cpu_mask,
    input  logic                        cpu_ack,
    input  logic                        dtc_done,
    output logic                        int_req,
    output logic [7:0]                  int_vector,
    output logic [PRIO_W-1:0]           int_level,
    output logic                        interrupt_exception_handling,
    output logic                        DTC_activate,
    output logic                        Disel,
    output logic                        ack_err
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    // Elaboration-time parameter sanity checks.
    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("irq_priority_ctrl: ACK_TIMEOUT must be at least 1");
    end
    if (NUM_IRQ < 1) begin : g_bad_num_irq
        $error("irq_priority_ctrl: NUM_IRQ must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOCK    = 3'd1,
        CPU_REQ = 3'd2,
        CPU_ACK = 3'd3,
        DTC_RUN = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   win_idx_q,    win_idx_d;
    logic [PRIO_W-1:0]  win_lvl_q,    win_lvl_d;
    logic               win_dtc_q,    win_dtc_d;

    logic               int_req_q,    int_req_d;
    logic [7:0]         int_vector_q, int_vector_d;
    logic [PRIO_W-1:0]  int_level_q,  int_level_d;
    logic               ieh_q,        ieh_d;
    logic               dtc_act_q,    dtc_act_d;
    logic               disel_q,      disel_d;

`ifdef IRQ_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               ack_err_q,    ack_err_d;
    logic               ack_expired;

    // This is the last CPU_REQ cycle before the wait budget is used up.
    assign ack_expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`endif

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    function automatic logic [PRIO_W-1:0] src_level(
        input logic [NUM_IRQ*PRIO_W-1:0] ipr,
        input int                        n
    );
        return ipr[n*PRIO_W +: PRIO_W];
    endfunction

    logic               arb_any;
    logic [IDX_W-1:0]   arb_idx;
    logic [PRIO_W-1:0]  arb_lvl;

    // The scan runs in ascending index order with a strict greater-than
    // compare. An equal level found later therefore never displaces an
    // earlier (lower-index) candidate. arb_lvl starts at 0, which also keeps
    // level-0 sources out of contention.
    always_comb begin
        arb_idx = '0;
        arb_lvl = '0;
        for (int n = 0; n < NUM_IRQ; n++) begin
            if (IRQ_req[n]
                && (src_level(IPR_dataout, n) != '0)
                && (src_level(IPR_dataout, n) > cpu_mask)
                && (src_level(IPR_dataout, n) > arb_lvl)) begin
                arb_idx = IDX_W'(n);
                arb_lvl = src_level(IPR_dataout, n);
            end
        end
        arb_any = (arb_lvl != '0);
    end

    // Whether the locked winner is still requesting service.
    logic win_req_held;
    assign win_req_held = IRQ_req[win_idx_q];

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        win_idx_d    = win_idx_q;
        win_lvl_d    = win_lvl_q;
        win_dtc_d    = win_dtc_q;
        int_req_d    = int_req_q;
        int_vector_d = int_vector_q;
        int_level_d  = int_level_q;
        ieh_d        = 1'b0;
        dtc_act_d    = dtc_act_q;
        disel_d      = disel_q;
`ifdef IRQ_ACK_TIMEOUT_EN
        cnt_d        = cnt_q;
        ack_err_d    = ack_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                int_req_d = 1'b0;
                dtc_act_d = 1'b0;
                disel_d   = 1'b0;
                if (arb_any) begin
                    win_idx_d = arb_idx;
                    win_lvl_d = arb_lvl;
                    win_dtc_d = DTCER_dataout[arb_idx];
                    state_d   = LOCK;
                end
            end

            // The winner was captured from last cycle's inputs. Confirm that
            // it still wants service before committing to either path.
            LOCK: begin
                if (!win_req_held) begin
                    state_d = IDLE;
                end else if (win_dtc_q) begin
                    dtc_act_d = 1'b1;
                    disel_d   = 1'b1;
                    state_d   = DTC_RUN;
                end else begin
                    int_req_d    = 1'b1;
                    int_vector_d = VEC_BASE + 8'(win_idx_q);
                    int_level_d  = win_lvl_q;
                    state_d      = CPU_REQ;
`ifdef IRQ_ACK_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end

            // An ack always takes precedence over a same-cycle withdrawal or
            // timeout, because the CPU has already committed to the vector.
            CPU_REQ: begin
                if (cpu_ack) begin
                    int_req_d = 1'b0;
                    ieh_d     = 1'b1;
                    state_d   = CPU_ACK;
`ifdef IRQ_ACK_TIMEOUT_EN
                end else if (ack_expired) begin
                    int_req_d = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = IDLE;
`endif
                end else if (!win_req_held) begin
                    int_req_d = 1'b0;
                    state_d   = IDLE;
                end else begin
`ifdef IRQ_ACK_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end

            // This single cycle carries the acceptance pulse. It also gives
            // the input unit one cycle to clear the source flag before the
            // next arbitration.
            CPU_ACK: begin
                state_d = IDLE;
            end

            // Request withdrawal is deliberately ignored here. Once the DTC
            // has been started, the transfer must run to completion.
            DTC_RUN: begin
                if (dtc_done) begin
                    dtc_act_d = 1'b0;
                    disel_d   = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                int_req_d = 1'b0;
                dtc_act_d = 1'b0;
                disel_d   = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_idx_q    <= '0;
            win_lvl_q    <= '0;
            win_dtc_q    <= 1'b0;
            int_req_q    <= 1'b0;
            int_vector_q <= '0;
            int_level_q  <= '0;
            ieh_q        <= 1'b0;
            dtc_act_q    <= 1'b0;
            disel_q      <= 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
            cnt_q        <= '0;
            ack_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            win_idx_q    <= win_idx_d;
            win_lvl_q    <= win_lvl_d;
            win_dtc_q    <= win_dtc_d;
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
            int_level_q  <= int_level_d;
            ieh_q        <= ieh_d;
            dtc_act_q    <= dtc_act_d;
            disel_q      <= disel_d;
`ifdef IRQ_ACK_TIMEOUT_EN
            cnt_q        <= cnt_d;
            ack_err_q    <= ack_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign int_req                      = int_req_q;
    assign int_vector                   = int_vector_q;
    assign int_level                    = int_level_q;
    assign interrupt_exception_handling = ieh_q;
    assign DTC_activate                 = dtc_act_q;
    assign Disel                        = disel_q;
`ifdef IRQ_ACK_TIMEOUT_EN
    assign ack_err                      = ack_err_q;
`else
    assign ack_err                      = 1'b0;
`endif

endmodule
